program_sequencer: RTL and testbench
====================================

// Module: program_sequencer
// PURPOSE
//  Program sequencer for the 5-stage pipelined core. Replaces switch-driven fetch as the instruction source.
//  Buffers a short program loaded over a valid/ready port, then issues one 8-bit instruction per cycle to the
//  fetch stage, honouring the hazard unit's stall. Drains the pipeline with NOPs and reports completion and issue counts.
// PARAMETERS
//  DEPTH       16  program buffer entries (power of 2)
//  AW          4   log2(DEPTH)
//  PIPE_DEPTH  5   drain cycles after last issue (IF/ID, ID/EX, EX/MEM, MEM/WB, WB register)
// PORTS
//  clk         in   1     clock
//  resetn      in   1     async active-low reset
//  clear       in   1     sync: abort, empty buffer, return to IDLE
//  load_valid  in   1     program word valid
//  load_data   in   8     instruction {mode, opcode[2:0], rA[1:0], rB[1:0]}
//  load_ready  out  1     buffer accepts word
//  start       in   1     begin/re-run program
//  stall       in   1     hazard-unit stall; pc holds while 1
//  instr_out   out  8     instruction presented to fetch stage
//  pc          out  AW    index of instr_out
//  busy        out  1     state is RUN or DRAIN
//  done        out  1     program finished and drained
//  issue_cnt   out  16    instructions accepted this run
//  stall_cnt   out  16    RUN cycles with stall=1 (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, wr_ptr=0, prog_len=0, pc=0, counters=0. instr_out=8'h00, load_ready=1, busy=0, done=0. RAM not cleared.
//  Priority per edge: resetn > clear > state logic. clear: IDLE, wr_ptr=prog_len=0, counters=0.
//  IDLE: load_ready = (wr_ptr != DEPTH). A handshake writes ram[wr_ptr] and increments wr_ptr (AW+1 bits).
//    start with length != 0 goes to RUN: pc=0, counters=0, prog_len=length. Length = wr_ptr + accepted load this edge.
//    start with length 0 is ignored.
//  RUN: instr_out = ram[pc] (async read). Accept = !stall.
//    On accept: issue_cnt++ (saturate 16'hFFFF).
//      If pc == prog_len-1: go to DRAIN with drain_cnt=PIPE_DEPTH; otherwise pc++.
//    stall=1: pc and instr_out hold; no issue.
//  DRAIN: instr_out=8'h00 (NOP). drain_cnt-- each edge; at drain_cnt==1 go to DONE. stall ignored.
//  DONE: done=1, instr_out=NOP, counters hold. start re-runs the same program (RUN, pc=0, counters cleared).
//    Loads are refused (load_ready=0).
//  load_ready=0 in RUN/DRAIN/DONE. instr_out=NOP in every state except RUN.
//  Timing: start at edge T puts ram[0] on instr_out in cycle T+1.
//    done rises exactly PIPE_DEPTH edges after the edge that accepts the last instruction.
//  Reset mid-run: immediate IDLE and empty buffer; a following start is ignored until reload.
// CONFIGURATION
//  SEQ_STALL_CNT_EN defined: stall_cnt counts RUN cycles with stall=1, saturating, cleared on start/clear/reset.
//  SEQ_STALL_CNT_EN undefined: stall_cnt is tied to 16'd0 and no counter logic is built.
// STRUCTURE
//  Shared package/include cpu_defs: opcode constants NOP=3'b000, ADD=3'b001, INC=3'b011;
//    instruction field positions (MODE=7, OPC=6:4, RA=3:2, RB=1:0); sequencer state encoding IDLE/RUN/DRAIN/DONE.
//  Sub-module program_ram: DEPTH x 8, one synchronous write port, one asynchronous read port. No reset on contents.
// TESTING
//  1 Reset: instr_out=00, busy=0, done=0, load_ready=1, issue_cnt=0, stall_cnt=0.
//  2 Load 13,34,00; start; stall=0: instr_out=13,34,00 on cycles 1-3, then NOP for 5 cycles.
//    done=1 at edge 8; issue_cnt=3.
//  3 Same program, stall=1 for 2 cycles while pc=1: instr_out holds 34, pc=1.
//    done delayed 2 cycles; stall_cnt=2 with SEQ_STALL_CNT_EN, 0 without.
//  4 Offer 17 words: load_ready drops after 16th; 17th not written; run issues 16, issue_cnt=16.
//  5 resetn low during RUN at pc=2: IDLE, busy=0, instr_out=00; start afterward ignored (prog_len=0).
//  6 DONE then start: re-run, issue_cnt restarts at 0. DONE then clear: IDLE, load_ready=1, wr_ptr=0.

Source files
------------

// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the 5-stage core and its program sequencer:
//   - instruction field positions and opcode constants
//   - sequencer geometry (buffer depth, pipeline drain length)
//   - sequencer state encoding
//   - saturating 16-bit increment helper
// Build option: SEQ_STALL_CNT_EN selects whether the stall counter exists
// (exported as STALL_CNT_EN so other code can key off it without macros).
// -----------------------------------------------------------------------------
package cpu_defs;

   // Instruction layout: {mode, opcode[2:0], rA[1:0], rB[1:0]}
   localparam int MODE_BIT = 7;
   localparam int OPC_MSB  = 6;
   localparam int OPC_LSB  = 4;
   localparam int RA_MSB   = 3;
   localparam int RA_LSB   = 2;
   localparam int RB_MSB   = 1;
   localparam int RB_LSB   = 0;

   localparam logic [2:0] OPC_NOP = 3'b000;
   localparam logic [2:0] OPC_ADD = 3'b001;
   localparam logic [2:0] OPC_INC = 3'b011;

   // All-zero word decodes as a NOP with mode 0 and r0,r0
   localparam logic [7:0] INSTR_NOP = 8'h00;

   // Sequencer geometry
   localparam int SEQ_DEPTH      = 16;
   localparam int SEQ_AW         = 4;
   localparam int SEQ_PIPE_DEPTH = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

`ifdef SEQ_STALL_CNT_EN
   localparam bit STALL_CNT_EN = 1'b1;
`else
   localparam bit STALL_CNT_EN = 1'b0;
`endif

   // Counters stick at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/program_sequencer_ram.sv
// -----------------------------------------------------------------------------
// program_ram
// DEPTH x 8 program buffer: one synchronous write port, one asynchronous read
// port. Contents are not reset.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_raddr  in   read address
//   o_rdata  out  read data (combinational from i_raddr)
// -----------------------------------------------------------------------------
module program_ram #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [DEPTH];

   // NOTE: storage arrays get no reset branch; a reset would turn the array
   // into DEPTH*8 resettable flops instead of a RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/program_sequencer.sv
// -----------------------------------------------------------------------------
// program_sequencer
// Instruction source for the 5-stage core. Buffers a short program loaded over
// a valid/ready port, issues one instruction per cycle to fetch while the
// hazard unit is not stalling, then presents NOPs for PIPE_DEPTH cycles to
// drain the pipeline before raising done.
// Build option: define SEQ_STALL_CNT_EN to build the stall counter; otherwise
// stall_cnt is tied to zero.
// Ports:
//   clk, resetn   clock, async active-low reset
//   clear         sync abort: empty buffer, counters to 0, back to IDLE
//   load_valid    program word offered
//   load_data     program word
//   load_ready    buffer accepts a word (IDLE and not full)
//   start         run (from IDLE with a non-empty buffer) or re-run (from DONE)
//   stall         hazard stall; holds pc/instr_out during RUN
//   instr_out     instruction to fetch (NOP outside RUN)
//   pc            buffer index of instr_out
//   busy          RUN or DRAIN
//   done          program issued and drained
//   issue_cnt     instructions accepted this run (saturating)
//   stall_cnt     RUN cycles with stall=1 (saturating, optional)
// -----------------------------------------------------------------------------
module program_sequencer
   import cpu_defs::*;
#(
   parameter int DEPTH      = SEQ_DEPTH,
   parameter int AW         = SEQ_AW,
   parameter int PIPE_DEPTH = SEQ_PIPE_DEPTH
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          clear,
   input  logic          load_valid,
   input  logic [7:0]    load_data,
   output logic          load_ready,
   input  logic          start,
   input  logic          stall,
   output logic [7:0]    instr_out,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          done,
   output logic [15:0]   issue_cnt,
   output logic [15:0]   stall_cnt
);

   localparam int DW = $clog2(PIPE_DEPTH + 1);

   seq_state_t    r_state,     w_state_nxt;
   logic [AW:0]   r_wr_ptr,    w_wr_ptr_nxt;    // one extra bit so "full" is DEPTH
   logic [AW:0]   r_prog_len,  w_prog_len_nxt;
   logic [AW-1:0] r_pc,        w_pc_nxt;
   logic [15:0]   r_issue_cnt, w_issue_nxt;
   logic [DW-1:0] r_drain_cnt, w_drain_nxt;

   logic          w_load_ready;
   logic          w_load_fire;
   logic [AW:0]   w_len;
   logic          w_last;
   logic [7:0]    w_rd_data;

   assign w_load_ready = (r_state == ST_IDLE) && (r_wr_ptr != (AW+1)'(DEPTH));
   assign w_load_fire  = load_valid && w_load_ready;
   // A word accepted on the same edge as start belongs to the program
   assign w_len        = r_wr_ptr + {{AW{1'b0}}, w_load_fire};
   assign w_last       = ({1'b0, r_pc} == (r_prog_len - (AW+1)'(1)));

   program_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_load_fire && !clear),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata (load_data),
      .i_raddr (r_pc),
      .o_rdata (w_rd_data)
   );

   // NOTE: sequential state uses <= so every register samples the pre-edge
   // values; blocking = here would create order-dependent races.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_wr_ptr    <= '0;
         r_prog_len  <= '0;
         r_pc        <= '0;
         r_issue_cnt <= '0;
         r_drain_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_prog_len  <= w_prog_len_nxt;
         r_pc        <= w_pc_nxt;
         r_issue_cnt <= w_issue_nxt;
         r_drain_cnt <= w_drain_nxt;
      end
   end

   // NOTE: every output of this block is given a hold value first so no path
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_wr_ptr_nxt   = r_wr_ptr;
      w_prog_len_nxt = r_prog_len;
      w_pc_nxt       = r_pc;
      w_issue_nxt    = r_issue_cnt;
      w_drain_nxt    = r_drain_cnt;

      if (clear) begin
         w_state_nxt    = ST_IDLE;
         w_wr_ptr_nxt   = '0;
         w_prog_len_nxt = '0;
         w_pc_nxt       = '0;
         w_issue_nxt    = '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_load_fire) begin
                  w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(1);
               end
               if (start && (w_len != '0)) begin
                  w_state_nxt    = ST_RUN;
                  w_pc_nxt       = '0;
                  w_issue_nxt    = '0;
                  w_prog_len_nxt = w_len;
               end
            end
            ST_RUN: begin
               if (!stall) begin
                  w_issue_nxt = sat_inc16(r_issue_cnt);
                  if (w_last) begin
                     w_state_nxt = ST_DRAIN;
                     w_drain_nxt = DW'(PIPE_DEPTH);
                  end else begin
                     w_pc_nxt = r_pc + AW'(1);
                  end
               end
            end
            ST_DRAIN: begin
               w_drain_nxt = r_drain_cnt - DW'(1);
               if (r_drain_cnt == DW'(1)) begin
                  w_state_nxt = ST_DONE;
               end
            end
            ST_DONE: begin
               if (start) begin
                  w_state_nxt = ST_RUN;
                  w_pc_nxt    = '0;
                  w_issue_nxt = '0;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

`ifdef SEQ_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   // Cleared on every transition into RUN, i.e. whenever issue_cnt clears
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_stall_cnt <= '0;
      end else if (clear) begin
         r_stall_cnt <= '0;
      end else if (start && (((r_state == ST_IDLE) && (w_len != '0)) ||
                             (r_state == ST_DONE))) begin
         r_stall_cnt <= '0;
      end else if ((r_state == ST_RUN) && stall) begin
         r_stall_cnt <= sat_inc16(r_stall_cnt);
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = 16'd0;
`endif

   assign load_ready = w_load_ready;
   assign instr_out  = (r_state == ST_RUN) ? w_rd_data : INSTR_NOP;
   assign pc         = r_pc;
   assign busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign done       = (r_state == ST_DONE);
   assign issue_cnt  = r_issue_cnt;

endmodule

// File: tb/tb_program_sequencer.sv
// -----------------------------------------------------------------------------
// tb_program_sequencer
// Self-checking bench for program_sequencer. The reference model tracks the
// buffered program as an array plus a word count; for each run it builds the
// expected per-cycle trace (instruction, pc, busy, done, issue count) as a
// queue from the program and a stall plan, then replays it against the DUT.
// -----------------------------------------------------------------------------
module tb_program_sequencer;
   import cpu_defs::*;

   logic        clk;
   logic        resetn;
   logic        clear;
   logic        load_valid;
   logic [7:0]  load_data;
   logic        load_ready;
   logic        start;
   logic        stall;
   logic [7:0]  instr_out;
   logic [3:0]  pc;
   logic        busy;
   logic        done;
   logic [15:0] issue_cnt;
   logic [15:0] stall_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model of the buffer
   logic [7:0] m_prog [16];
   int         m_wr;

   typedef struct {
      logic [7:0]  instr;
      int          pc;
      bit          chk_pc;
      bit          busy;
      bit          stall;
      logic [15:0] issued;
   } exp_t;

   exp_t exp_q[$];

   program_sequencer dut (
      .clk        (clk),
      .resetn     (resetn),
      .clear      (clear),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .start      (start),
      .stall      (stall),
      .instr_out  (instr_out),
      .pc         (pc),
      .busy       (busy),
      .done       (done),
      .issue_cnt  (issue_cnt),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Step one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer n words; load_ready is checked against the model before each edge
   task automatic load_words(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         logic [7:0] w;
         bit         exp_rdy;
         w          = 8'($urandom);
         exp_rdy    = (m_wr < 16);
         load_valid = 1'b1;
         load_data  = w;
         #1;
         n_cmp++;
         if (load_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL %s load_ready word%0d: got %b, expected %b", tag, i, load_ready, exp_rdy);
         end
         if (exp_rdy) begin
            m_prog[m_wr] = w;
            m_wr++;
         end
         tick();
      end
      load_valid = 1'b0;
   endtask

   // Start a run from IDLE or DONE and replay the expected trace.
   // stall_pc/stall_len force a stall burst before issuing that index;
   // max_stall adds random stalls elsewhere. with_load accepts one more word
   // on the start edge.
   task automatic run_program(input string tag, input int max_stall, input int stall_pc,
                              input int stall_len, input bit with_load);
      int          exp_stalls;
      logic [15:0] issued;
      exp_t        e;
      int          cyc;

      exp_q.delete();
      if (with_load) begin
         logic [7:0] w;
         w          = 8'($urandom);
         load_valid = 1'b1;
         load_data  = w;
         if (m_wr < 16) begin
            m_prog[m_wr] = w;
            m_wr++;
         end
      end

      exp_stalls = 0;
      issued     = 16'd0;
      for (int idx = 0; idx < m_wr; idx++) begin
         int k;
         k = (idx == stall_pc) ? stall_len : ((max_stall > 0) ? $urandom_range(0, max_stall) : 0);
         for (int j = 0; j < k; j++) begin
            e = '{instr: m_prog[idx], pc: idx, chk_pc: 1'b1, busy: 1'b1, stall: 1'b1, issued: issued};
            exp_q.push_back(e);
         end
         exp_stalls += k;
         e = '{instr: m_prog[idx], pc: idx, chk_pc: 1'b1, busy: 1'b1, stall: 1'b0, issued: issued};
         exp_q.push_back(e);
         issued++;
      end
      for (int d = 0; d < SEQ_PIPE_DEPTH; d++) begin
         e = '{instr: INSTR_NOP, pc: 0, chk_pc: 1'b0, busy: 1'b1,
               stall: 1'($urandom_range(0, 1)), issued: issued};
         exp_q.push_back(e);
      end

      start = 1'b1;
      tick();
      start      = 1'b0;
      load_valid = 1'b0;

      cyc = 0;
      while (exp_q.size() > 0) begin
         e     = exp_q.pop_front();
         stall = e.stall;
         n_cmp++;
         if (instr_out !== e.instr || (e.chk_pc && pc !== 4'(e.pc)) || busy !== e.busy ||
             done !== 1'b0 || issue_cnt !== e.issued) begin
            n_err++;
            $display("FAIL %s cyc%0d: instr=%h pc=%0d busy=%b done=%b issue=%0d; expected instr=%h pc=%0d busy=%b done=0 issue=%0d",
                     tag, cyc, instr_out, pc, busy, done, issue_cnt, e.instr, e.pc, e.busy, e.issued);
         end
         tick();
         cyc++;
      end
      stall = 1'b0;

      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || instr_out !== INSTR_NOP || load_ready !== 1'b0) begin
         n_err++;
         $display("FAIL %s done_state: done=%b busy=%b instr=%h load_ready=%b; expected 1 0 00 0",
                  tag, done, busy, instr_out, load_ready);
      end
      n_cmp++;
      if (issue_cnt !== 16'(m_wr)) begin
         n_err++;
         $display("FAIL %s issue_cnt: got %0d, expected %0d", tag, issue_cnt, m_wr);
      end
      n_cmp++;
      if (stall_cnt !== (STALL_CNT_EN ? 16'(exp_stalls) : 16'd0)) begin
         n_err++;
         $display("FAIL %s stall_cnt: got %0d, expected %0d", tag, stall_cnt,
                  STALL_CNT_EN ? exp_stalls : 0);
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      m_wr  = 0;
   endtask

   task automatic test_reset();
      resetn     = 1'b0;
      clear      = 1'b0;
      load_valid = 1'b0;
      load_data  = 8'h00;
      start      = 1'b0;
      stall      = 1'b0;
      m_wr       = 0;
      #12;
      n_cmp++;
      if (instr_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1 ||
          issue_cnt !== 16'd0 || stall_cnt !== 16'd0 || pc !== 4'd0) begin
         n_err++;
         $display("FAIL reset: instr=%h busy=%b done=%b ready=%b issue=%0d stall=%0d pc=%0d; expected 00 0 0 1 0 0 0",
                  instr_out, busy, done, load_ready, issue_cnt, stall_cnt, pc);
      end
      @(negedge clk);
      resetn = 1'b1;
      tick();
      n_cmp++;
      if (busy !== 1'b0 || load_ready !== 1'b1 || instr_out !== 8'h00) begin
         n_err++;
         $display("FAIL post_reset: busy=%b ready=%b instr=%h; expected 0 1 00", busy, load_ready, instr_out);
      end
   endtask

   task automatic load_fixed();
      logic [7:0] words [3];
      words = '{8'h13, 8'h34, 8'h00};
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data  = words[i];
         m_prog[m_wr] = words[i];
         m_wr++;
         tick();
      end
      load_valid = 1'b0;
   endtask

   task automatic test_basic_run();
      do_clear();
      load_fixed();
      run_program("basic", 0, -1, 0, 1'b0);
   endtask

   task automatic test_stall();
      run_program("stall_pc1", 0, 1, 2, 1'b0);
   endtask

   task automatic test_full_buffer();
      do_clear();
      load_words("full", 17);
      run_program("full_run", 1, -1, 0, 1'b0);
   endtask

   task automatic test_load_with_start();
      do_clear();
      load_words("lws", 2);
      run_program("load_with_start", 1, -1, 0, 1'b1);
   endtask

   task automatic test_reset_mid_run();
      do_clear();
      load_words("rst", 4);
      start = 1'b1;
      tick();
      start = 1'b0;
      stall = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (pc !== 4'd2 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL rst_pre: pc=%0d busy=%b; expected 2 1", pc, busy);
      end
      #2;
      resetn = 1'b0;
      m_wr   = 0;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || instr_out !== 8'h00 || done !== 1'b0 || load_ready !== 1'b1 ||
          issue_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL rst_async: busy=%b instr=%h done=%b ready=%b issue=%0d; expected 0 00 0 1 0",
                  busy, instr_out, done, load_ready, issue_cnt);
      end
      @(negedge clk);
      resetn = 1'b1;
      start  = 1'b1;
      tick();
      start = 1'b0;
      tick();
      n_cmp++;
      if (busy !== 1'b0 || instr_out !== 8'h00 || done !== 1'b0) begin
         n_err++;
         $display("FAIL rst_start_ignored: busy=%b instr=%h done=%b; expected 0 00 0", busy, instr_out, done);
      end
   endtask

   task automatic test_done_rerun_clear();
      do_clear();
      load_words("rerun", 5);
      run_program("first", 1, -1, 0, 1'b0);
      // Loads offered in DONE are refused; the model buffer stays unchanged
      load_valid = 1'b1;
      load_data  = 8'hA5;
      tick();
      load_valid = 1'b0;
      run_program("rerun", 2, -1, 0, 1'b0);
      do_clear();
      n_cmp++;
      if (load_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || issue_cnt !== 16'd0 ||
          stall_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL clear_from_done: ready=%b busy=%b done=%b issue=%0d stall=%0d; expected 1 0 0 0 0",
                  load_ready, busy, done, issue_cnt, stall_cnt);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL clear_empty_start: busy=%b done=%b; expected 0 0", busy, done);
      end
   endtask

   task automatic test_random_programs();
      for (int it = 0; it < 6; it++) begin
         do_clear();
         load_words("rand_load", $urandom_range(1, 16));
         run_program("rand_run", 3, -1, 0, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_basic_run();
      test_stall();
      test_full_buffer();
      test_load_with_start();
      test_reset_mid_run();
      test_done_rerun_clear();
      test_random_programs();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
